// File: rtl/piso_stream_ctrl_pkg.sv
// piso_pkg: shared state encoding and default geometry for piso_stream_ctrl.
// No ports. Exports: state_t (IDLE, STREAM), PISO_DEPTH, PISO_WIDTH.
package piso_pkg;
   typedef enum logic {IDLE = 1'b0, STREAM = 1'b1} state_t;
   localparam int PISO_DEPTH = 16;
   localparam int PISO_WIDTH = 8;
endpackage

// File: rtl/piso_stream_ctrl_if.sv
// piso_stream_ctrl_if: batch handshake, bank strobes and output byte stream.
// Signals:
//   batch_valid/batch_ready  batch handshake from the compute array
//   flush                    synchronous abort of the current batch
//   piso_load/piso_shift     strobes to the bank; piso_sout is the bank's serial output
//   out_data/out_valid/out_ready/out_idx/out_last  byte stream towards the sink
// Modports: master = controller side, slave = environment (array, bank, sink).
interface piso_stream_ctrl_if
   import piso_pkg::*;
#(
   parameter int WIDTH = PISO_WIDTH,
   parameter int IDX_W = $clog2(PISO_DEPTH)
);
   logic batch_valid, batch_ready, flush, piso_load, piso_shift, out_valid, out_ready, out_last;
   logic [WIDTH-1:0] piso_sout, out_data;
   logic [IDX_W-1:0] out_idx;
   modport master (
      input  batch_valid, flush, piso_sout, out_ready,
      output batch_ready, piso_load, piso_shift, out_data, out_valid, out_idx, out_last
   );
   modport slave (
      output batch_valid, flush, piso_sout, out_ready,
      input  batch_ready, piso_load, piso_shift, out_data, out_valid, out_idx, out_last
   );
endinterface

// File: rtl/piso_stream_ctrl_stall_counter.sv
// piso_stall_counter: saturating stall-cycle and completed-batch counters.
// Ports: clk, rst (async active-low), stall (valid beat not taken this cycle),
//        done (last beat accepted this cycle), stall_cnt[31:0], batch_cnt[15:0].
module piso_stall_counter (
   input  logic        clk,
   input  logic        rst,
   input  logic        stall,
   input  logic        done,
   output logic [31:0] stall_cnt,
   output logic [15:0] batch_cnt
);
   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         stall_cnt <= '0;
         batch_cnt <= '0;
      end else begin
         if (stall && !(&stall_cnt)) stall_cnt <= stall_cnt + 1'b1;
         if (done && !(&batch_cnt)) batch_cnt <= batch_cnt + 1'b1;
      end
endmodule

// File: rtl/piso_stream_ctrl.sv
// piso_stream_ctrl: loads a DEPTH x WIDTH PISO bank and drains it as a valid/ready byte stream.
// Ports: clk, rst (async active-low), s (piso_stream_ctrl_if.master: batch handshake,
//        flush, bank load/shift strobes, serial input, output stream with index/last).
// Optional: define PISO_STALL_CNT_EN to add stall_cnt[31:0] and batch_cnt[15:0].
module piso_stream_ctrl
   import piso_pkg::*;
#(
   parameter int DEPTH = PISO_DEPTH,
   parameter int WIDTH = PISO_WIDTH,
   parameter int IDX_W = $clog2(DEPTH)
) (
   input logic clk,
   input logic rst,
   piso_stream_ctrl_if.master s
`ifdef PISO_STALL_CNT_EN
   ,
   output logic [31:0] stall_cnt,
   output logic [15:0] batch_cnt
`endif
);
   state_t state, state_nx;
   logic [IDX_W-1:0] idx, idx_nx;
   logic streaming, last, accept, done;
   assign streaming = state == STREAM;
   assign last      = idx == IDX_W'(DEPTH - 1);
   assign accept    = streaming && s.out_ready;
   assign done      = accept && last;
   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         state <= IDLE;
         idx   <= '0;
      end else begin
         state <= state_nx;
         idx   <= idx_nx;
      end
   // A load on the final beat keeps us in STREAM with no idle bubble.
   always_comb begin
      state_nx = s.flush ? IDLE : s.piso_load ? STREAM : done ? IDLE : state;
      idx_nx   = (s.flush || s.piso_load) ? '0 : s.piso_shift ? idx + 1'b1 : idx;
   end
   // The last beat needs no shift; the bank is either reloaded or abandoned.
   always_comb begin
      s.batch_ready = !s.flush && (!streaming || done);
      s.piso_load   = s.batch_valid && s.batch_ready;
      s.piso_shift  = !s.flush && accept && !last;
      s.out_valid   = streaming;
      s.out_data    = WIDTH'(s.piso_sout);
      s.out_idx     = idx;
      s.out_last    = streaming && last;
   end
`ifdef PISO_STALL_CNT_EN
   piso_stall_counter u_cnt (
      .clk       (clk),
      .rst       (rst),
      .stall     (streaming && !s.out_ready),
      .done      (done),
      .stall_cnt (stall_cnt),
      .batch_cnt (batch_cnt)
   );
`endif
endmodule

// File: tb/tb_piso_stream_ctrl.sv
// tb_piso_stream_ctrl: bench for piso_stream_ctrl with a behavioural 16x8 bank and beat scoreboard.
module tb_piso_stream_ctrl;
   import piso_pkg::*;
   localparam int D  = PISO_DEPTH;
   localparam int W  = PISO_WIDTH;
   localparam int IW = $clog2(D);
   typedef struct packed {logic [W-1:0] d; logic [IW-1:0] i; logic l;} beat_t;
   logic clk = 0;
   logic rst = 0;
   logic [W-1:0] bank [D];
   logic [W-1:0] pv [D];
   beat_t sb [$];
   beat_t got, exp;
   int checks = 0;
   int errors = 0;
   piso_stream_ctrl_if #(.WIDTH(W), .IDX_W(IW)) s ();
`ifdef PISO_STALL_CNT_EN
   logic [31:0] stall_cnt;
   logic [15:0] batch_cnt;
`endif
   piso_stream_ctrl #(.DEPTH(D), .WIDTH(W), .IDX_W(IW)) dut (
      .clk (clk),
      .rst (rst),
      .s   (s)
`ifdef PISO_STALL_CNT_EN
      ,
      .stall_cnt (stall_cnt),
      .batch_cnt (batch_cnt)
`endif
   );
   always #5 clk = ~clk;
   assign s.piso_sout = bank[0];
   // Bank model: entry 0 presented on sout; every load queues the DEPTH beats it must produce.
   always @(posedge clk)
      if (rst) begin
         checks++;
         if (s.piso_load && s.piso_shift) begin
            errors++;
            $display("FAIL strobes: load=1 shift=1, required mutually exclusive");
         end
         if (s.piso_load) begin
            bank <= pv;
            for (int k = 0; k < D; k++) sb.push_back('{pv[k], IW'(k), k == D - 1});
         end else if (s.piso_shift)
            for (int k = 0; k < D - 1; k++) bank[k] <= bank[k+1];
      end
   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end
   task automatic test_reset();
      rst = 0;
      #1;
      checks++;
      if ({s.out_valid, s.out_last, s.out_idx, s.piso_load, s.piso_shift} !== '0) begin
         errors++;
         $display("FAIL reset_outputs: valid=%b last=%b idx=%0d load=%b shift=%b, required all 0",
                  s.out_valid, s.out_last, s.out_idx, s.piso_load, s.piso_shift);
      end
      repeat (2) @(negedge clk);
      rst = 1;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         #1;
         checks++;
         if ({s.batch_ready, s.out_valid, s.piso_load, s.piso_shift} !== 4'b1000) begin
            errors++;
            $display("FAIL idle: ready=%b valid=%b load=%b shift=%b, required 1 0 0 0",
                     s.batch_ready, s.out_valid, s.piso_load, s.piso_shift);
         end
      end
   endtask
   task automatic test_single();
      int shifts = 0;
      for (int k = 0; k < D; k++) pv[k] = W'(k);
      @(negedge clk);
      s.batch_valid = 1;
      s.out_ready   = 1;
      #1;
      checks++;
      if ({s.piso_load, s.batch_ready} !== 2'b11) begin
         errors++;
         $display("FAIL single_load: load=%b ready=%b, required 1 1", s.piso_load, s.batch_ready);
      end
      @(negedge clk);
      s.batch_valid = 0;
      #1;
      for (int c = 0; c < D; c++) begin
         checks++;
         if (s.out_valid !== 1'b1) begin
            errors++;
            $display("FAIL single_valid: cycle %0d valid=%b, required 1", c, s.out_valid);
         end
         got = '{s.out_data, s.out_idx, s.out_last};
         if (sb.size() > 0) exp = sb.pop_front(); else exp = 'x;
         checks++;
         if (got !== exp) begin
            errors++;
            $display("FAIL single_beat: got d=%h idx=%0d last=%b, required d=%h idx=%0d last=%b",
                     got.d, got.i, got.l, exp.d, exp.i, exp.l);
         end
         shifts += int'(s.piso_shift);
         @(negedge clk);
         #1;
      end
      checks++;
      if (shifts != D - 1) begin
         errors++;
         $display("FAIL single_shifts: got %0d, required %0d", shifts, D - 1);
      end
      checks++;
      if ({s.out_valid, s.batch_ready} !== 2'b01) begin
         errors++;
         $display("FAIL single_end: valid=%b ready=%b, required 0 1", s.out_valid, s.batch_ready);
      end
   endtask
   task automatic test_backpressure();
      int beats = 0;
      logic stalled = 0;
      beat_t prev = '0;
      for (int k = 0; k < D; k++) pv[k] = W'(8'h30 + k);
      @(negedge clk);
      s.batch_valid = 1;
      #1;
      @(negedge clk);
      s.batch_valid = 0;
      for (int c = 0; c < 60 && beats < D; c++) begin
         s.out_ready = (c % 3 == 0);
         #1;
         checks++;
         if (s.out_valid !== 1'b1) begin
            errors++;
            $display("FAIL bp_valid: cycle %0d valid=%b, required 1", c, s.out_valid);
         end
         got = '{s.out_data, s.out_idx, s.out_last};
         if (stalled) begin
            checks++;
            if (got !== prev) begin
               errors++;
               $display("FAIL bp_stable: got d=%h idx=%0d, required d=%h idx=%0d", got.d, got.i, prev.d, prev.i);
            end
         end
         prev = got;
         if (s.out_ready) begin
            if (sb.size() > 0) exp = sb.pop_front(); else exp = 'x;
            checks++;
            if (got !== exp) begin
               errors++;
               $display("FAIL bp_beat: got d=%h idx=%0d last=%b, required d=%h idx=%0d last=%b",
                        got.d, got.i, got.l, exp.d, exp.i, exp.l);
            end
            beats++;
            stalled = 0;
         end else begin
            checks++;
            if (s.piso_shift !== 1'b0) begin
               errors++;
               $display("FAIL bp_shift: shift=%b during stall, required 0", s.piso_shift);
            end
            stalled = 1;
         end
         @(negedge clk);
      end
      s.out_ready = 1;
      #1;
      checks++;
      if (beats != D || s.out_valid !== 1'b0) begin
         errors++;
         $display("FAIL bp_count: beats=%0d valid_after=%b, required %0d 0", beats, s.out_valid, D);
      end
   endtask
   task automatic test_back_to_back();
      for (int k = 0; k < D; k++) pv[k] = W'(8'h10 + k);
      @(negedge clk);
      s.batch_valid = 1;
      s.out_ready   = 1;
      @(negedge clk);
      for (int k = 0; k < D; k++) pv[k] = W'(8'h20 + k);
      for (int c = 0; c < 2 * D; c++) begin
         if (c == D) s.batch_valid = 0;
         #1;
         checks++;
         if (s.out_valid !== 1'b1) begin
            errors++;
            $display("FAIL b2b_valid: cycle %0d valid=%b, required 1", c, s.out_valid);
         end
         got = '{s.out_data, s.out_idx, s.out_last};
         if (sb.size() > 0) exp = sb.pop_front(); else exp = 'x;
         checks++;
         if (got !== exp) begin
            errors++;
            $display("FAIL b2b_beat: got d=%h idx=%0d last=%b, required d=%h idx=%0d last=%b",
                     got.d, got.i, got.l, exp.d, exp.i, exp.l);
         end
         if (c == D - 1 || c == 2 * D - 1) begin
            checks++;
            if (s.piso_load !== (c == D - 1)) begin
               errors++;
               $display("FAIL b2b_load: cycle %0d load=%b, required %b", c, s.piso_load, c == D - 1);
            end
         end
         @(negedge clk);
      end
      #1;
      checks++;
      if (s.out_valid !== 1'b0) begin
         errors++;
         $display("FAIL b2b_end: valid=%b, required 0", s.out_valid);
      end
   endtask
   task automatic test_flush();
      for (int k = 0; k < D; k++) pv[k] = W'(8'h40 + k);
      @(negedge clk);
      s.batch_valid = 1;
      @(negedge clk);
      s.batch_valid = 0;
      for (int c = 0; c < D; c++) begin
         #1;
         got = '{s.out_data, s.out_idx, s.out_last};
         if (sb.size() > 0) exp = sb.pop_front(); else exp = 'x;
         checks++;
         if (got !== exp) begin
            errors++;
            $display("FAIL flush_beat: got d=%h idx=%0d, required d=%h idx=%0d", got.d, got.i, exp.d, exp.i);
         end
         if (got.i == IW'(5)) break;
         @(negedge clk);
      end
      s.flush       = 1;
      s.batch_valid = 1;
      #1;
      checks++;
      if ({s.piso_load, s.piso_shift, s.batch_ready} !== 3'b000) begin
         errors++;
         $display("FAIL flush_strobes: load=%b shift=%b ready=%b, required 0 0 0",
                  s.piso_load, s.piso_shift, s.batch_ready);
      end
      @(negedge clk);
      s.flush       = 0;
      s.batch_valid = 0;
      #1;
      checks++;
      if ({s.out_valid, s.batch_ready, s.out_idx} !== {2'b01, IW'(0)}) begin
         errors++;
         $display("FAIL flush_idle: valid=%b ready=%b idx=%0d, required 0 1 0", s.out_valid, s.batch_ready, s.out_idx);
      end
      sb.delete();
      for (int k = 0; k < D; k++) pv[k] = W'(8'h50 + k);
      s.batch_valid = 1;
      @(negedge clk);
      s.batch_valid = 0;
      for (int c = 0; c < D; c++) begin
         #1;
         got = '{s.out_data, s.out_idx, s.out_last};
         if (sb.size() > 0) exp = sb.pop_front(); else exp = 'x;
         checks++;
         if (got !== exp || s.out_valid !== 1'b1) begin
            errors++;
            $display("FAIL flush_restart: valid=%b got d=%h idx=%0d last=%b, required d=%h idx=%0d last=%b",
                     s.out_valid, got.d, got.i, got.l, exp.d, exp.i, exp.l);
         end
         @(negedge clk);
      end
   endtask
   task automatic test_async_reset();
      for (int k = 0; k < D; k++) pv[k] = W'(8'h60 + k);
      @(negedge clk);
      s.batch_valid = 1;
      @(negedge clk);
      s.batch_valid = 0;
      for (int c = 0; c < D; c++) begin
         #1;
         got = '{s.out_data, s.out_idx, s.out_last};
         if (sb.size() > 0) exp = sb.pop_front(); else exp = 'x;
         checks++;
         if (got !== exp) begin
            errors++;
            $display("FAIL arst_beat: got d=%h idx=%0d, required d=%h idx=%0d", got.d, got.i, exp.d, exp.i);
         end
         if (got.i == IW'(9)) break;
         @(negedge clk);
      end
      #1;
      rst = 0;
      #1;
      checks++;
      if ({s.out_valid, s.out_last, s.out_idx, s.piso_load, s.piso_shift} !== '0) begin
         errors++;
         $display("FAIL arst_clear: valid=%b last=%b idx=%0d load=%b shift=%b, required all 0",
                  s.out_valid, s.out_last, s.out_idx, s.piso_load, s.piso_shift);
      end
      sb.delete();
      @(negedge clk);
      rst = 1;
      @(negedge clk);
      #1;
      checks++;
      if ({s.batch_ready, s.out_valid} !== 2'b10) begin
         errors++;
         $display("FAIL arst_release: ready=%b valid=%b, required 1 0", s.batch_ready, s.out_valid);
      end
   endtask
`ifdef PISO_STALL_CNT_EN
   task automatic test_stall_cnt();
      for (int k = 0; k < D; k++) pv[k] = W'(8'h70 + k);
      @(negedge clk);
      s.out_ready   = 0;
      s.batch_valid = 1;
      @(negedge clk);
      s.batch_valid = 0;
      repeat (3) @(negedge clk);
      s.out_ready = 1;
      for (int c = 0; c < D; c++) begin
         #1;
         got = '{s.out_data, s.out_idx, s.out_last};
         if (sb.size() > 0) exp = sb.pop_front(); else exp = 'x;
         checks++;
         if (got !== exp) begin
            errors++;
            $display("FAIL cnt_beat: got d=%h idx=%0d, required d=%h idx=%0d", got.d, got.i, exp.d, exp.i);
         end
         @(negedge clk);
      end
      checks++;
      if (stall_cnt !== 32'd3 || batch_cnt !== 16'd1) begin
         errors++;
         $display("FAIL counters: stall_cnt=%0d batch_cnt=%0d, required 3 1", stall_cnt, batch_cnt);
      end
   endtask
`endif
   initial begin
      s.batch_valid = 0;
      s.flush       = 0;
      s.out_ready   = 1;
      test_reset();
      test_single();
      test_backpressure();
      test_back_to_back();
      test_flush();
      test_async_reset();
`ifdef PISO_STALL_CNT_EN
      test_stall_cnt();
`endif
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
